// File: rtl/eth_bridge_pkg.sv
// Shared bridge definitions: frame length limits, counter width and controller state encoding.
// One-hot state codes are common to the transmit and receive controllers.
package eth_bridge_pkg;

  localparam int ETH_LEN_W   = 16;
  localparam int ETH_MIN_LEN = 60;
  localparam int ETH_MAX_LEN = 1518;

  typedef logic [3:0] state_t;

  localparam state_t RESYNC = 4'b0001;
  localparam state_t IDLE   = 4'b0010;
  localparam state_t RECV   = 4'b0100;
  localparam state_t DROP   = 4'b1000;

endpackage

// File: rtl/rx_frame_stats.sv
// Wrapping good/dropped frame counters; each updates in the same cycle as its commit/discard pulse.
module rx_frame_stats #(
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_ok,
  input  logic             inc_drop,
  output logic [LEN_W-1:0] frames_ok,
  output logic [LEN_W-1:0] frames_drop
);

  logic [LEN_W-1:0] ok_q, ok_d;
  logic [LEN_W-1:0] drop_q, drop_d;

  always_comb begin
    ok_d   = inc_ok   ? ok_q + LEN_W'(1)   : ok_q;
    drop_d = inc_drop ? drop_q + LEN_W'(1) : drop_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ok_q   <= '0;
      drop_q <= '0;
    end else begin
      ok_q   <= ok_d;
      drop_q <= drop_d;
    end
  end

  assign frames_ok   = ok_q;
  assign frames_drop = drop_q;

endmodule

// File: rtl/rx_control.sv
// MAC RX to frame buffer writer: commits good frames and pushes their length, rewinds bad ones.
// One cycle from accepted byte to registered write; buf_full/len_full drop the frame rather than stall.
module rx_control
  import eth_bridge_pkg::*;
#(
  parameter int MIN_LEN = ETH_MIN_LEN,
  parameter int MAX_LEN = ETH_MAX_LEN,
  parameter int LEN_W   = ETH_LEN_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  input  logic             rx_last,
  input  logic             rx_error,
  input  logic             buf_full,
  input  logic             len_full,
  output logic             wr_en,
  output logic [7:0]       wr_data,
  output logic             commit,
  output logic             discard,
  output logic             len_wr,
  output logic [LEN_W-1:0] len_data,
  output logic [LEN_W-1:0] frames_ok,
  output logic [LEN_W-1:0] frames_drop
);

  localparam logic [LEN_W-1:0] MIN_L = LEN_W'(MIN_LEN);
  localparam logic [LEN_W-1:0] MAX_L = LEN_W'(MAX_LEN);

  state_t           state_q, state_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic             wr_en_q, wr_en_d;
  logic [7:0]       wr_data_q, wr_data_d;
  logic             commit_q, commit_d;
  logic             discard_q, discard_d;
  logic             len_wr_q, len_wr_d;
  logic [LEN_W-1:0] len_data_q, len_data_d;

  logic [LEN_W-1:0] frame_len;
  logic             abort;
  logic             frame_good;

  // A byte beyond MAX_LEN is never written, even when it carries rx_last.
  assign frame_len  = cnt_q + LEN_W'(1);
  assign abort      = buf_full || (cnt_q == MAX_L);
  assign frame_good = (frame_len >= MIN_L) && !rx_error && !len_full;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= RESYNC;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RESYNC, DROP: if (!rx_valid || rx_last) state_d = IDLE;
      IDLE:         if (rx_valid && !rx_last) state_d = RECV;
      RECV: begin
        if (!rx_valid || rx_last) state_d = IDLE;
        else if (abort)           state_d = DROP;
      end
      default:      state_d = RESYNC;
    endcase
  end

  always_comb begin
    cnt_d      = cnt_q;
    wr_en_d    = 1'b0;
    wr_data_d  = rx_data;
    commit_d   = 1'b0;
    discard_d  = 1'b0;
    len_wr_d   = 1'b0;
    len_data_d = '0;
    case (state_q)
      IDLE: begin
        if (rx_valid) begin
          wr_en_d   = 1'b1;
          cnt_d     = LEN_W'(1);
          discard_d = rx_last;
        end
      end
      RECV: begin
        if (!rx_valid || abort) begin
          discard_d = 1'b1;
          cnt_d     = '0;
        end else if (rx_last) begin
          wr_en_d    = 1'b1;
          cnt_d      = '0;
          commit_d   = frame_good;
          len_wr_d   = frame_good;
          len_data_d = frame_good ? frame_len : '0;
          discard_d  = !frame_good;
        end else begin
          wr_en_d = 1'b1;
          cnt_d   = frame_len;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q      <= '0;
      wr_en_q    <= 1'b0;
      wr_data_q  <= '0;
      commit_q   <= 1'b0;
      discard_q  <= 1'b0;
      len_wr_q   <= 1'b0;
      len_data_q <= '0;
    end else begin
      cnt_q      <= cnt_d;
      wr_en_q    <= wr_en_d;
      wr_data_q  <= wr_data_d;
      commit_q   <= commit_d;
      discard_q  <= discard_d;
      len_wr_q   <= len_wr_d;
      len_data_q <= len_data_d;
    end
  end

  rx_frame_stats #(
    .LEN_W (LEN_W)
  ) u_stats (
    .clk         (clk),
    .rst         (rst),
    .inc_ok      (commit_d),
    .inc_drop    (discard_d),
    .frames_ok   (frames_ok),
    .frames_drop (frames_drop)
  );

  assign wr_en    = wr_en_q;
  assign wr_data  = wr_data_q;
  assign commit   = commit_q;
  assign discard  = discard_q;
  assign len_wr   = len_wr_q;
  assign len_data = len_data_q;

endmodule

// File: tb/tb_rx_control.sv
// Scoreboard bench for rx_control: expected writes and frame outcomes are queued as bytes are driven.
module tb_rx_control;

  localparam int LEN_W   = 16;
  localparam int MIN_LEN = 60;
  localparam int MAX_LEN = 1518;

  logic             clk = 1'b0;
  logic             rst;
  logic [7:0]       rx_data;
  logic             rx_valid, rx_last, rx_error, buf_full, len_full;
  logic             wr_en, commit, discard, len_wr;
  logic [7:0]       wr_data;
  logic [LEN_W-1:0] len_data, frames_ok, frames_drop;

  typedef struct {
    bit disc;
    int len;
    bit with_wr;
  } ev_t;

  logic [7:0] exp_wr[$];
  ev_t        exp_ev[$];
  int         exp_ok, exp_drop;
  int         n_cmp, n_err;
  bit         ignore;

  rx_control #(
    .MIN_LEN (MIN_LEN),
    .MAX_LEN (MAX_LEN),
    .LEN_W   (LEN_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_last     (rx_last),
    .rx_error    (rx_error),
    .buf_full    (buf_full),
    .len_full    (len_full),
    .wr_en       (wr_en),
    .wr_data     (wr_data),
    .commit      (commit),
    .discard     (discard),
    .len_wr      (len_wr),
    .len_data    (len_data),
    .frames_ok   (frames_ok),
    .frames_drop (frames_drop)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    rx_valid = 1'b0;
    rx_last  = 1'b0;
    rx_error = 1'b0;
    buf_full = 1'b0;
    len_full = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_wr_en"},    wr_en, 0);
    chk({tag, "_wr_data"},  wr_data, 0);
    chk({tag, "_commit"},   commit, 0);
    chk({tag, "_discard"},  discard, 0);
    chk({tag, "_len_wr"},   len_wr, 0);
    chk({tag, "_len_data"}, len_data, 0);
    chk({tag, "_ok"},       frames_ok, 0);
    chk({tag, "_drop"},     frames_drop, 0);
  endtask

  // full_at: 1-based byte index at which buf_full is raised for one cycle (0 = never)
  task automatic send_frame(input int n, input bit err, input int full_at,
                            input bit lfull, input bit gap);
    int   lim, dec_at;
    ev_t  ev;
    lim    = (full_at != 0) ? full_at - 1 : ((n > MAX_LEN) ? MAX_LEN : n);
    dec_at = (full_at != 0) ? full_at : ((n > MAX_LEN) ? MAX_LEN + 1 : n);
    ev.len     = n;
    ev.disc    = (full_at != 0) || (n > MAX_LEN) || (n < MIN_LEN) || err || lfull;
    ev.with_wr = (full_at == 0) && (n <= MAX_LEN);
    for (int i = 1; i <= n; i++) begin
      @(posedge clk); #1;
      rx_valid = 1'b1;
      rx_data  = 8'($urandom);
      rx_last  = (i == n);
      rx_error = err && (i == n);
      buf_full = (i == full_at);
      len_full = lfull;
      if (i <= lim) exp_wr.push_back(rx_data);
      if (i == dec_at) begin
        exp_ev.push_back(ev);
        if (ev.disc) exp_drop++;
        else         exp_ok++;
      end
    end
    if (gap) begin
      @(posedge clk); #1;
      idle_inputs();
    end
  endtask

  task automatic drain_check(input string tag);
    repeat (4) @(posedge clk);
    #1;
    chk({tag, "_wr_left"}, exp_wr.size(), 0);
    chk({tag, "_ev_left"}, exp_ev.size(), 0);
    chk({tag, "_frames_ok"}, frames_ok, exp_ok);
    chk({tag, "_frames_drop"}, frames_drop, exp_drop);
    exp_wr.delete();
    exp_ev.delete();
  endtask

  always @(negedge clk) begin
    if (rst && !ignore) begin
      if (wr_en) begin
        chk("wr_expected", exp_wr.size() > 0, 1);
        if (exp_wr.size() > 0) chk("wr_data", wr_data, exp_wr.pop_front());
      end
      if (commit || discard || len_wr) begin
        chk("len_wr_eq_commit", len_wr, commit);
        chk("commit_discard_excl", commit && discard, 0);
        chk("ev_expected", exp_ev.size() > 0, 1);
        if (exp_ev.size() > 0) begin
          ev_t o;
          o = exp_ev.pop_front();
          chk("ev_discard", discard, o.disc);
          chk("ev_with_wr_en", wr_en, o.with_wr);
          if (!o.disc) chk("len_data", len_data, o.len);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    n_cmp = 0; n_err = 0; exp_ok = 0; exp_drop = 0; ignore = 1'b0;
    idle_inputs();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b1;
    repeat (2) @(posedge clk);

    send_frame(64, 0, 0, 0, 1);
    drain_check("good64");

    send_frame(59, 0, 0, 0, 1);
    send_frame(60, 0, 0, 0, 1);
    send_frame(1, 0, 0, 0, 1);
    drain_check("runt");

    send_frame(100, 1, 0, 0, 0);
    send_frame(64, 0, 0, 0, 1);
    drain_check("fcs_b2b");

    send_frame(200, 0, 30, 0, 1);
    send_frame(64, 0, 0, 0, 1);
    drain_check("overflow");

    send_frame(1519, 0, 0, 0, 1);
    send_frame(MAX_LEN, 0, 0, 0, 1);
    send_frame(64, 0, 0, 1, 1);
    send_frame(64, 0, 0, 0, 0);
    send_frame(70, 0, 0, 0, 1);
    drain_check("oversize_lenfull");

    // reset in the middle of a frame: no writes until that frame's tail has passed
    ignore = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      rx_valid = 1'b1;
      rx_data  = 8'($urandom);
      rx_last  = (i == 40);
      if (i == 20) begin
        rst = 1'b0;
        exp_wr.delete();
        exp_ev.delete();
        exp_ok = 0;
        exp_drop = 0;
        ignore = 1'b0;
      end
      if (i == 22) check_all_zero("mid_reset");
      if (i == 25) rst = 1'b1;
    end
    @(posedge clk); #1;
    idle_inputs();
    drain_check("resync");
    send_frame(64, 0, 0, 0, 1);
    drain_check("after_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
